// File: rtl/bcd_timer_pkg.sv
// ---------------------------------------------------------------------------
// bcd_timer_pkg
// Shared constants and helpers for the cascaded BCD down-timer.
//   DIGIT_W           width of one BCD digit
//   BCD_MAX_DEC       maximum of an ordinary decimal digit
//   BCD_MAX_SEC_TENS  maximum of the tens-of-seconds digit (mod-6)
//   digit_max()       per-digit maximum, given digit index and seconds mode
// ---------------------------------------------------------------------------
package bcd_timer_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX_DEC      = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MAX_SEC_TENS = 4'd5;

  // Digit 1 becomes the tens-of-seconds digit in MM:SS layout.
  function automatic logic [DIGIT_W-1:0] digit_max(input int idx, input int sec_mode);
    if ((sec_mode != 0) && (idx == 1)) begin
      return BCD_MAX_SEC_TENS;
    end
    return BCD_MAX_DEC;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// ---------------------------------------------------------------------------
// bcd_down_digit
// One cell of the BCD down-counter chain: synchronous clear, parallel load
// and borrow-driven decrement with wrap to MAX.
// Optional feature macro: BCD_DOWN_TIMER_CLAMP_EN (clamp loaded digits to MAX).
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high reset (digit <= 0)
//   load       load data_in on this edge
//   data_in    load value for this digit
//   borrow_in  decrement this digit on this edge
//   digit      registered digit value
//   is_zero    digit == 0
// ---------------------------------------------------------------------------
module bcd_down_digit
  import bcd_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = BCD_MAX_DEC
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] data_in,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               is_zero
);

  logic [DIGIT_W-1:0] digit_reg;
  logic [DIGIT_W-1:0] load_val;

`ifdef BCD_DOWN_TIMER_CLAMP_EN
  // Out-of-range keypad entries are saturated so count is always valid BCD.
  assign load_val = (data_in > MAX) ? MAX : data_in;
`else
  // Stored verbatim; an invalid digit counts down in binary until it is valid.
  assign load_val = data_in;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      digit_reg <= '0;
    end else if (borrow_in) begin
      digit_reg <= (digit_reg == '0) ? MAX : digit_reg - 1'b1;
    end else if (load) begin
      digit_reg <= load_val;
    end
  end

  assign digit   = digit_reg;
  assign is_zero = (digit_reg == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// ---------------------------------------------------------------------------
// bcd_down_timer
// Parametrised multi-digit BCD down-counter (MM:SS capable) for the oven
// countdown display.
// Optional feature macro: BCD_DOWN_TIMER_CLAMP_EN (clamp loaded digits to MAX).
// Parameters:
//   DIGITS        number of digits (1..8), digit 0 least significant
//   SEC_MODE      1: digit 1 is mod-6 (tens of seconds)
//   STOP_AT_ZERO  1: hold at all-zero, 0: wrap to all-MAX
// Ports:
//   clk    rising-edge clock
//   clr    synchronous active-high reset
//   en     count enable, one decrement per clock
//   loadn  active-low synchronous load, only while en=0
//   data   load value, digit i at [4i+3:4i]
//   count  registered current value
//   zero   all digits zero (combinational)
//   tc     zero & en (combinational), cascade enable for an upstream chain
//   done   one-cycle registered pulse when a decrement reaches zero
// ---------------------------------------------------------------------------
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SEC_MODE     = 1,
  parameter int STOP_AT_ZERO = 1
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      en,
  input  logic                      loadn,
  input  logic [DIGIT_W*DIGITS-1:0] data,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      zero,
  output logic                      tc,
  output logic                      done
);

  localparam int CW = DIGIT_W * DIGITS;

  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] borrow;
  logic              step;
  logic              load;
  logic              done_reg;
  logic              done_next;

  assign zero = &is_zero;
  assign tc   = zero & en;

  // In halt mode the all-zero state swallows the decrement entirely.
  assign step = en & ~((STOP_AT_ZERO != 0) & zero);
  assign load = ~en & ~loadn;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign borrow[gi] = step;
      end else begin : g_upper
        assign borrow[gi] = borrow[gi-1] & is_zero[gi-1];
      end

      bcd_down_digit #(
        .MAX(digit_max(gi, SEC_MODE))
      ) u_digit (
        .clk      (clk),
        .clr      (clr),
        .load     (load),
        .data_in  (data[gi*DIGIT_W +: DIGIT_W]),
        .borrow_in(borrow[gi]),
        .digit    (count[gi*DIGIT_W +: DIGIT_W]),
        .is_zero  (is_zero[gi])
      );
    end
  endgenerate

  // The only non-zero value a decrement takes to zero is exactly 1, so
  // loading zero or sitting at zero never raises done.
  assign done_next = en & (count == CW'(1));

  always_ff @(posedge clk) begin
    if (clr) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= done_next;
    end
  end

  assign done = done_reg;

endmodule
